// File: rtl/code_tx_pkg.sv
// code_tx_pkg: shared state encoding and default geometry for the serial
// unlock-code transmitter.
package code_tx_pkg;
   localparam int CODE_W_DEF  = 4;
   localparam int GAP_DEF     = 1;
   localparam int TIMEOUT_DEF = 8;
   typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_GAP, ST_WAIT_RESP, ST_DONE} state_t;
endpackage

// File: rtl/code_tx_cnt.sv
// code_tx_cnt: loadable down-counter with zero flag, timing both the
// inter-bit gap and the response wait.
module code_tx_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load ? load_val : (dec && !zero) ? cnt_q - W'(1) : cnt_q;
   assign zero = cnt_q == '0;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/code_ser_tx.sv
// code_ser_tx: shifts a latched unlock code out MSB-first to a lock and
// reports the lock's answer or a timeout. Optional: CODE_TX_RETRY_EN.
module code_ser_tx
   import code_tx_pkg::*;
#(
   parameter int CODE_W  = CODE_W_DEF,
   parameter int GAP     = GAP_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              code_val,
   input  logic [CODE_W-1:0] code_data,
   output logic              code_rdy,
   output logic              ser_val,
   output logic              ser_data,
   input  logic              output_val,
   input  logic              output_data,
   output logic              res_val,
   output logic              res_ok,
   output logic              res_to,
   output logic              busy
);
   state_t            state_q, state_d;
   logic [CODE_W-1:0] sh_q, sh_d, rot;
   logic [7:0]        bits_q, bits_d, cnt_val;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic              code_rdy_q, code_rdy_d, ser_val_q, ser_val_d, ser_data_q, ser_data_d;
   logic              res_val_q, res_val_d, res_ok_q, res_ok_d, res_to_q, res_to_d, busy_q, busy_d;
`ifdef CODE_TX_RETRY_EN
   logic              retry_q, retry_d;
`endif

   code_tx_cnt #(.W(8)) u_cnt (
      .clk(clk), .rstn(rstn), .load(cnt_load), .load_val(cnt_val), .dec(cnt_dec), .zero(cnt_zero)
   );

   // Rotating rather than shifting leaves the original code in place after the last bit.
   assign rot = (sh_q << 1) | (sh_q >> (CODE_W - 1));

   always_comb begin
      state_d    = state_q;
      sh_d       = sh_q;
      bits_d     = bits_q;
      ser_val_d  = 1'b0;
      ser_data_d = 1'b0;
      res_val_d  = 1'b0;
      res_ok_d   = res_ok_q;
      res_to_d   = res_to_q;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      cnt_dec    = 1'b0;
`ifdef CODE_TX_RETRY_EN
      retry_d    = retry_q;
`endif
      case (state_q)
         ST_IDLE: if (code_val && code_rdy_q) begin
            state_d    = ST_SEND;
            sh_d       = code_data;
            bits_d     = 8'(CODE_W - 1);
            ser_val_d  = 1'b1;
            ser_data_d = code_data[CODE_W-1];
`ifdef CODE_TX_RETRY_EN
            retry_d    = 1'b0;
`endif
         end
         ST_SEND: begin
            sh_d = rot;
            if (bits_q == 8'd0) begin
               if (output_val) begin
                  state_d   = ST_DONE;
                  res_val_d = 1'b1;
                  res_ok_d  = output_data;
                  res_to_d  = 1'b0;
               end else begin
                  state_d  = ST_WAIT_RESP;
                  cnt_load = 1'b1;
                  cnt_val  = 8'(TIMEOUT - 1);
               end
            end else begin
               bits_d = bits_q - 8'd1;
               if (GAP > 0) begin
                  state_d  = ST_GAP;
                  cnt_load = 1'b1;
                  cnt_val  = 8'(GAP - 1);
               end else begin
                  ser_val_d  = 1'b1;
                  ser_data_d = rot[CODE_W-1];
               end
            end
         end
         ST_GAP: begin
            cnt_dec = 1'b1;
            if (cnt_zero) begin
               state_d    = ST_SEND;
               ser_val_d  = 1'b1;
               ser_data_d = sh_q[CODE_W-1];
            end
         end
         ST_WAIT_RESP: begin
            cnt_dec = 1'b1;
            if (output_val || cnt_zero) begin
               state_d   = ST_DONE;
               res_val_d = 1'b1;
               res_ok_d  = output_val & output_data;
               res_to_d  = !output_val;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
`ifdef CODE_TX_RETRY_EN
            if (!res_val_q) begin
               state_d    = ST_SEND;
               bits_d     = 8'(CODE_W - 1);
               ser_val_d  = 1'b1;
               ser_data_d = sh_q[CODE_W-1];
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef CODE_TX_RETRY_EN
      // A first failed attempt enters DONE silently and resends from there.
      if (res_val_d && !res_ok_d && !retry_q) begin
         res_val_d = 1'b0;
         res_ok_d  = res_ok_q;
         res_to_d  = res_to_q;
         retry_d   = 1'b1;
      end
`endif
      code_rdy_d = state_d == ST_IDLE;
      busy_d     = state_d != ST_IDLE;
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state_q    <= ST_IDLE;
         sh_q       <= '0;
         bits_q     <= '0;
         code_rdy_q <= 1'b0;
         ser_val_q  <= 1'b0;
         ser_data_q <= 1'b0;
         res_val_q  <= 1'b0;
         res_ok_q   <= 1'b0;
         res_to_q   <= 1'b0;
         busy_q     <= 1'b0;
`ifdef CODE_TX_RETRY_EN
         retry_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sh_q       <= sh_d;
         bits_q     <= bits_d;
         code_rdy_q <= code_rdy_d;
         ser_val_q  <= ser_val_d;
         ser_data_q <= ser_data_d;
         res_val_q  <= res_val_d;
         res_ok_q   <= res_ok_d;
         res_to_q   <= res_to_d;
         busy_q     <= busy_d;
`ifdef CODE_TX_RETRY_EN
         retry_q    <= retry_d;
`endif
      end

   assign code_rdy = code_rdy_q;
   assign ser_val  = ser_val_q;
   assign ser_data = ser_data_q;
   assign res_val  = res_val_q;
   assign res_ok   = res_ok_q;
   assign res_to   = res_to_q;
   assign busy     = busy_q;
endmodule

// File: doc/code_ser_tx.md
CODE_SER_TX -- requirements
Module: code_ser_tx

Interface
REQ-001 Parameter CODE_W, default 4: width of the unlock code word, in bits.
REQ-002 Parameter GAP, default 1: idle cycles inserted between consecutive bits, range 0..15.
REQ-003 Parameter TIMEOUT, default 8: response wait limit, in cycles after the last bit, range 1..255.
REQ-004 clk  input  1  rising-edge clock; the only clock.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 code_val  input  1  parallel code offered.
REQ-007 code_data  input  CODE_W  code word; the MSB is sent first.
REQ-008 code_rdy  output  1  code accepted on an edge where code_val and code_rdy are both 1.
REQ-009 ser_val  output  1  serial bit strobe to the lock.
REQ-010 ser_data  output  1  serial bit value; qualified by ser_val.
REQ-011 output_val  input  1  lock response valid (Mealy; may assert combinationally during the last bit).
REQ-012 output_data  input  1  lock response: 1 = unlocked.
REQ-013 res_val  output  1  one-cycle result pulse.
REQ-014 res_ok  output  1  unlock confirmed; qualified by res_val.
REQ-015 res_to  output  1  timeout flag; qualified by res_val.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, SEND, GAP, WAIT_RESP and DONE; all outputs are registered.
REQ-018 IDLE SHALL drive code_rdy=1; on handshake, latch code_data into a shift register and go to SEND.
- First bit appears on ser_val/ser_data in the cycle after the handshake.
REQ-019 SEND SHALL drive ser_val=1 for exactly one cycle per bit, MSB first, then:
- GAP>0 and bits remain: go to GAP.
- GAP=0 and bits remain: stay in SEND, so bits are back-to-back.
- Last bit: go to WAIT_RESP.
REQ-020 GAP SHALL drive ser_val=0 and ser_data=0 for exactly GAP cycles, then return to SEND.
REQ-021 output_val SHALL be sampled in the last-bit SEND cycle and in every WAIT_RESP cycle; the first assertion ends the wait.
REQ-022 Response sampled -> DONE with res_ok=output_data and res_to=0.
REQ-023 WAIT_RESP cycle count reaches TIMEOUT with no response -> DONE with res_ok=0 and res_to=1.
REQ-024 DONE SHALL assert res_val for exactly one cycle, then go to IDLE.
- res_ok/res_to hold their value until the next DONE.
REQ-025 output_val asserted outside the sampling windows SHALL be ignored.
REQ-026 code_val while busy=1 SHALL be ignored; code_rdy=0 in every state except IDLE.
REQ-027 ser_data SHALL be 0 whenever ser_val=0.

Reset
REQ-028 rstn=0 SHALL clear immediately, without waiting for clk, regardless of state (including mid-code):
- State to IDLE; shift register and counters to 0.
- ser_val=0, ser_data=0, res_val=0, res_ok=0, res_to=0, busy=0, code_rdy=0.
REQ-029 code_rdy SHALL rise on the first clk edge after rstn deasserts.

Configuration
REQ-030 With CODE_TX_RETRY_EN defined, a DONE result with res_ok=0 on the first attempt SHALL retransmit the same latched code once:
- DONE goes back to SEND without pulsing res_val; res_val pulses only after the second attempt.
REQ-031 Without CODE_TX_RETRY_EN, every attempt SHALL produce res_val directly and no retry logic is present.

Structure
REQ-032 Package code_tx_pkg SHALL hold the state enum and the default values of CODE_W, GAP and TIMEOUT.
REQ-033 One sub-module, code_tx_cnt, SHALL be used: a loadable down-counter with a zero flag, shared by GAP and WAIT_RESP timing.

Verification
All scenarios use CODE_W=4 and GAP=1; cycle 0 is the handshake edge.
REQ-034 Send 4'b1011:
- ser_val=1 at cycles 1, 3, 5, 7 with ser_data 1, 0, 1, 1.
- Lock responds output_val=1, output_data=1 at cycle 7 -> res_val=1, res_ok=1, res_to=0 at cycle 8.
REQ-035 Send 4'b1011 with no response -> res_val=1, res_to=1, res_ok=0 at cycle 8+TIMEOUT (TIMEOUT=8 gives cycle 16).
REQ-036 code_val held high through a transaction with a different code_data -> second code is not accepted until after res_val; ser stream unchanged.
REQ-037 rstn=0 at cycle 4 -> ser_val=0 and busy=0 at once, state IDLE; code_rdy=1 one edge after rstn release.
REQ-038 Response output_data=0:
- With CODE_TX_RETRY_EN: second 1,0,1,1 burst, then a single res_val.
- Without it: res_val with res_ok=0 and no retransmission.
REQ-039 GAP=0 -> ser_val high for 4 consecutive cycles (cycles 1-4).
